gdp_job_arbiter: RTL and testbench

- Shares one GDP summation datapath between NREQ requesters.
- Arbitration is round-robin. For each job the block sequences the datapath: clear, start, wait for done, capture the sum, acknowledge the requester.
- A timeout counter guards against a GDP that never asserts done.
- Sits between requester logic and the GDP instance; the GDP remains an unmodified sub-block driven only by this controller.

---
 rtl/gdp_pkg.sv | 24 ++
 rtl/gdp_rr_pick.sv | 38 +++
 rtl/gdp_job_arbiter.sv | 136 +++++++++++++
 tb/tb_gdp_job_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gdp_pkg.sv
// gdp_pkg
// Shared definitions for the GDP job arbiter slice:
//   - state_t     : controller FSM encoding (IDLE..DELIVER)
//   - DEFAULT_*   : default parameter values used by the top level
//   - ptr_width() : index width for a requester count (never below 1)
package gdp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DELIVER = 3'd4
  } state_t;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_W       = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gdp_rr_pick.sv
// gdp_rr_pick
// Combinational round-robin priority picker. Returns the first set bit of
// req, searching upward from rr_ptr and wrapping at NREQ.
// Ports:
//   req     in  [NREQ-1:0]  request vector
//   rr_ptr  in  [PW-1:0]    index with highest priority this round
//   grant   out [PW-1:0]    selected index (0 when any_req is low)
//   any_req out             at least one request is pending
module gdp_rr_pick
  import gdp_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   grant,
  output logic            any_req
);

  int idx;

  // Walk offsets from the farthest to the nearest so the nearest set bit
  // (lowest offset from rr_ptr) is the last one written and wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) begin
        grant   = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gdp_job_arbiter.sv
// gdp_job_arbiter
// Shares one GDP summation datapath between NREQ requesters. Requesters are
// picked round-robin; each job runs CLEAR -> LAUNCH -> WAIT -> DELIVER.
// A timeout counter closes a job with result_err when gdp_done never comes.
// Ports:
//   clk, restart        clock (rising edge), async active-high reset
//   req, n_in           request levels and packed operands (k uses [k*W +: W])
//   ack                 one-cycle pulse to the served requester
//   result, result_err  job sum / timeout flag, valid in the ack cycle
//   grant_id, busy      requester being served, controller not idle
//   gdp_clear/start/n   control and operand towards the GDP
//   gdp_sum/done        GDP result and done level
//   fsm_state           current controller state, for observation
//
// Handshake: req[k] is a level held until ack[k]. A request that is still
// high after its ack is treated as a new request and rejoins the rotation.
// A request dropped after grant still completes and is acked.
module gdp_job_arbiter
  import gdp_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            restart,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] n_in,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    result,
  output logic            result_err,
  output logic [2:0]      grant_id,
  output logic            busy,
  output logic            gdp_clear,
  output logic            gdp_start,
  output logic [W-1:0]    gdp_n,
  input  logic [W-1:0]    gdp_sum,
  input  logic            gdp_done,
  output state_t          fsm_state
);

  localparam int PW = ptr_width(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_n;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_q;
  logic [W-1:0]  n_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  result_q;
  logic          err_q;

  logic [PW-1:0] pick;
  logic          any_req;
  logic          timed_out;

  gdp_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  // Counter reaches TIMEOUT on this WAIT cycle if it is currently one short.
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (any_req) state_n = ST_CLEAR;
      ST_CLEAR:   state_n = ST_LAUNCH;
      ST_LAUNCH:  state_n = ST_WAIT;
      ST_WAIT:    if (gdp_done || timed_out) state_n = ST_DELIVER;
      ST_DELIVER: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      n_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            n_q     <= n_in[int'(pick)*W +: W];
          end
        end
        ST_LAUNCH: cnt <= '0;
        ST_WAIT: begin
          // done has priority over a coinciding timeout
          if (gdp_done) begin
            result_q <= gdp_sum;
            err_q    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (timed_out) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        ST_DELIVER: begin
          rr_ptr <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state == ST_DELIVER) ack[grant_q] = 1'b1;
  end

  assign result     = result_q;
  assign result_err = err_q;
  assign grant_id   = 3'(grant_q);
  assign busy       = (state != ST_IDLE);
  assign gdp_clear  = (state == ST_CLEAR);
  assign gdp_start  = (state == ST_LAUNCH);
  assign gdp_n      = n_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_gdp_job_arbiter.sv
module tb_gdp_job_arbiter;
  import gdp_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            restart;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] n_in;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    result;
  logic            result_err;
  logic [2:0]      grant_id;
  logic            busy;
  logic            gdp_clear;
  logic            gdp_start;
  logic [W-1:0]    gdp_n;
  logic [W-1:0]    gdp_sum = '0;
  logic            gdp_done = 1'b0;
  state_t          fsm_state;

  int errors = 0;
  int checks = 0;

  gdp_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(255)) dut (
    .clk        (clk),
    .restart    (restart),
    .req        (req),
    .n_in       (n_in),
    .ack        (ack),
    .result     (result),
    .result_err (result_err),
    .grant_id   (grant_id),
    .busy       (busy),
    .gdp_clear  (gdp_clear),
    .gdp_start  (gdp_start),
    .gdp_n      (gdp_n),
    .gdp_sum    (gdp_sum),
    .gdp_done   (gdp_done),
    .fsm_state  (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bench GDP: sum = n(n+1)/2 mod 2^W, done high n cycles after start
  // (one cycle for n<=1), done held until gdp_clear. gdp_never blocks done.
  logic       gdp_never = 1'b0;
  logic [7:0] m_cnt = '0;
  logic [7:0] m_n = '0;
  logic       m_run = 1'b0;

  function automatic logic [7:0] tri_sum(input logic [7:0] n);
    int v;
    v = int'(n);
    return 8'((v * (v + 1)) / 2);
  endfunction

  always @(posedge clk) begin
    if (gdp_clear) begin
      gdp_done <= 1'b0;
      m_run    <= 1'b0;
    end else if (gdp_start && !gdp_never) begin
      m_n <= gdp_n;
      if (gdp_n <= 8'd1) begin
        gdp_done <= 1'b1;
        gdp_sum  <= tri_sum(gdp_n);
      end else begin
        m_cnt <= gdp_n - 8'd1;
        m_run <= 1'b1;
      end
    end else if (m_run) begin
      if (m_cnt == 8'd1) begin
        gdp_done <= 1'b1;
        gdp_sum  <= tri_sum(m_n);
        m_run    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 8'd1;
      end
    end
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_ack(input int max, output int cyc, output logic seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) seen = 1'b1;
    end
  endtask

  // Waits for the next ack and checks it; exp_cyc counts negedges from the call.
  task automatic expect_ack(input string tag, input int id, input logic [7:0] res,
                            input logic err, input int exp_cyc, input logic drop);
    int   cyc;
    logic seen;
    wait_ack(exp_cyc + 20, cyc, seen);
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << id));
      check({tag, "_grant"}, 32'(grant_id), 32'(id));
      check({tag, "_result"}, 32'(result), 32'(res));
      check({tag, "_err"}, 32'(result_err), 32'(err));
      if (drop) req[id] = 1'b0;
      @(negedge clk);
      check({tag, "_ack_pulse"}, 32'(ack), 32'd0);
      check({tag, "_result_held"}, 32'(result), 32'(res));
    end
  endtask

  initial begin
    restart = 1'b1;
    req     = '0;
    n_in    = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err", 32'(result_err), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clear", 32'(gdp_clear), 32'd0);
    check("rst_start", 32'(gdp_start), 32'd0);
    check("rst_gdp_n", 32'(gdp_n), 32'd0);
    restart = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Test 1: req[0], n=5 -> clear T+1, start T+2, ack T+8 with 15
    n_in[0 +: 8] = 8'd5;
    req[0] = 1'b1;
    @(negedge clk);
    check("t1_clear", 32'(gdp_clear), 32'd1);
    check("t1_start_lo", 32'(gdp_start), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_gdp_n", 32'(gdp_n), 32'd5);
    @(negedge clk);
    check("t1_start", 32'(gdp_start), 32'd1);
    check("t1_clear_lo", 32'(gdp_clear), 32'd0);
    expect_ack("t1", 0, 8'd15, 1'b0, 6, 1'b1);

    // Test 2: req[2], n=128 -> 64; then n=0 -> 0 at minimum latency
    n_in[16 +: 8] = 8'd128;
    req[2] = 1'b1;
    expect_ack("t2a", 2, 8'd64, 1'b0, 131, 1'b1);
    n_in[16 +: 8] = 8'd0;
    req[2] = 1'b1;
    expect_ack("t2b", 2, 8'd0, 1'b0, 4, 1'b1);

    // Test 3: fresh pointer, all four requests; req[0] stays high
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_in = {8'd4, 8'd3, 8'd2, 8'd1};
    req  = 4'b1111;
    expect_ack("t3_r0", 0, 8'd1, 1'b0, 4, 1'b0);
    expect_ack("t3_r1", 1, 8'd3, 1'b0, 5, 1'b1);
    expect_ack("t3_r2", 2, 8'd6, 1'b0, 6, 1'b1);
    expect_ack("t3_r3", 3, 8'd10, 1'b0, 7, 1'b1);
    expect_ack("t3_r0again", 0, 8'd1, 1'b0, 4, 1'b1);

    // Test 4: done never arrives -> timeout after 255 WAIT cycles
    gdp_never = 1'b1;
    n_in[8 +: 8] = 8'd7;
    req[1] = 1'b1;
    expect_ack("t4", 1, 8'd0, 1'b1, 258, 1'b1);
    check("t4_idle", 32'(busy), 32'd0);
    gdp_never = 1'b0;

    // Test 5: stale done from previous job must not leak into the next
    n_in[16 +: 8] = 8'd3;
    req[2] = 1'b1;
    expect_ack("t5a", 2, 8'd6, 1'b0, 6, 1'b1);
    n_in[24 +: 8] = 8'd10;
    req[3] = 1'b1;
    expect_ack("t5b", 3, 8'd55, 1'b0, 13, 1'b1);

    // Test 6: restart during WAIT abandons the job, which then reruns
    n_in[8 +: 8] = 8'd20;
    req[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_in_wait", 32'(fsm_state), 32'(ST_WAIT));
    restart = 1'b1;
    #1;
    check("t6_rst_ack", 32'(ack), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_result", 32'(result), 32'd0);
    check("t6_rst_grant", 32'(grant_id), 32'd0);
    check("t6_rst_gdp_n", 32'(gdp_n), 32'd0);
    check("t6_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    check("t6_hold_ack", 32'(ack), 32'd0);
    restart = 1'b0;
    expect_ack("t6", 1, 8'd210, 1'b0, 23, 1'b1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
